// File: rtl/emif_csr_rst_ctrl.sv
// -----------------------------------------------------------------------------
// emif_csr_rst_ctrl
//
// Reset sequencer and CSR block for the EMIF memory subsystem. It holds the
// memory subsystem in reset for RST_CYCLES cycles, then waits for every present
// channel to calibrate. The wait ends in DONE, or in FAIL on a channel fail or
// a timeout. The calibration result is latched into a status register. Host
// software reads these registers through a 64-bit CSR port:
//   0x00 DFH (constant), 0x08 status, 0x10 capability, 0x18 control.
//
// Optional build macro: EMIF_CSR_SCRATCH_EN adds a 64-bit scratch register at
// 0x20. It is cleared only by rst and is not touched by control triggers.
//
// Ports:
//   clk               CSR and sequencer clock
//   rst               synchronous active-high reset
//   csr_addr          byte address, bits [2:0] ignored
//   csr_write         write strobe (single cycle)
//   csr_writedata     write data
//   csr_read          read strobe (single cycle)
//   csr_readdata      read data, valid with csr_readdatavalid
//   csr_readdatavalid read response, one cycle after csr_read
//   mem_rst           active-high reset to the memory subsystem
//   cal_success       per-channel calibration pass (level)
//   cal_fail          per-channel calibration fail (level)
//   mem_ready         high only while the sequencer is in DONE
// -----------------------------------------------------------------------------
module emif_csr_rst_ctrl #(
    parameter int          NUM_CH      = 4,
    parameter logic [7:0]  CH_MASK     = 8'h0F,
    parameter logic [63:0] DFH_VAL     = 64'h3_00000_00B000_1009,
    parameter int          RST_CYCLES  = 16,
    parameter int          CAL_TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       csr_addr,
    input  logic              csr_write,
    input  logic [63:0]       csr_writedata,
    input  logic              csr_read,
    output logic [63:0]       csr_readdata,
    output logic              csr_readdatavalid,
    output logic              mem_rst,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail,
    output logic              mem_ready
);

    typedef enum logic [1:0] {
        RST_ASSERT = 2'd0,
        WAIT_CAL   = 2'd1,
        DONE       = 2'd2,
        FAIL       = 2'd3
    } state_t;

    // The reset-hold count and the calibration timeout are never needed at the
    // same time, so one counter serves both phases.
    localparam int CNT_MAX = (RST_CYCLES > CAL_TIMEOUT) ? RST_CYCLES : CAL_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CAL_LAST = CNT_W'(CAL_TIMEOUT - 1);
    localparam logic [NUM_CH-1:0] MASK     = CH_MASK[NUM_CH-1:0];

    // Word addresses (byte address >> 3).
    localparam logic [8:0] A_DFH = 9'h0;
    localparam logic [8:0] A_STS = 9'h1;
    localparam logic [8:0] A_CAP = 9'h2;
    localparam logic [8:0] A_CTL = 9'h3;
`ifdef EMIF_CSR_SCRATCH_EN
    localparam logic [8:0] A_SCR = 9'h4;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                snap_en;
    logic                timeout_hit;
    logic [NUM_CH-1:0]   snap_succ_q, snap_fail_q;
    logic                timeout_q;
    logic [63:0]         rd_mux;
    logic [8:0]          word;
    logic                ctrl_trig;
    logic                any_fail, all_ok;

    // Address bits below the 64-bit word and the non-trigger control bits are
    // intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{csr_addr[2:0], csr_writedata[63:1]};

    assign word      = csr_addr[11:3];
    assign ctrl_trig = csr_write && (word == A_CTL) && csr_writedata[0];
    assign any_fail  = |(cal_fail & MASK);
    assign all_ok    = &(cal_success | ~MASK);

    // Next-state logic. The control trigger overrides everything, including a
    // calibration result arriving in the same cycle.
    // NOTE: every signal written here is given a default first so that no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_en     = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            RST_ASSERT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_CAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_CAL: begin
                // Fail has priority over success, and both over the timeout.
                if (any_fail) begin
                    state_d = FAIL;
                    snap_en = 1'b1;
                end else if (all_ok) begin
                    state_d = DONE;
                    snap_en = 1'b1;
                end else if (cnt_q == CAL_LAST) begin
                    state_d     = FAIL;
                    snap_en     = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE, FAIL: ;
        endcase
        if (ctrl_trig) begin
            state_d     = RST_ASSERT;
            cnt_d       = '0;
            snap_en     = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    // mem_rst and mem_ready are registered from the next state, so they line
    // up exactly with state_q without a combinational path to the outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_ASSERT;
            cnt_q     <= '0;
            mem_rst   <= 1'b1;
            mem_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_rst   <= (state_d == RST_ASSERT);
            mem_ready <= (state_d == DONE);
        end
    end

    // Status sticky bits: captured on the WAIT_CAL exit edge, cleared by rst
    // or by a control trigger.
    always_ff @(posedge clk) begin
        if (rst || ctrl_trig) begin
            snap_succ_q <= '0;
            snap_fail_q <= '0;
            timeout_q   <= 1'b0;
        end else if (snap_en) begin
            snap_succ_q <= cal_success;
            snap_fail_q <= cal_fail;
            timeout_q   <= timeout_hit;
        end
    end

`ifdef EMIF_CSR_SCRATCH_EN
    logic [63:0] scratch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q <= '0;
        end else if (csr_write && (word == A_SCR)) begin
            scratch_q <= csr_writedata;
        end
    end
`endif

    // Read mux sees current register values, so a read that coincides with a
    // write returns the pre-write data.
    always_comb begin
        rd_mux = '0;
        case (word)
            A_DFH: rd_mux = DFH_VAL;
            A_STS: begin
                rd_mux[NUM_CH-1:0]   = snap_succ_q;
                rd_mux[8 +: NUM_CH]  = snap_fail_q;
                rd_mux[16]           = timeout_q;
                rd_mux[18:17]        = state_q;
            end
            A_CAP: begin
                rd_mux[7:0]  = CH_MASK;
                rd_mux[11:8] = 4'(NUM_CH);
            end
`ifdef EMIF_CSR_SCRATCH_EN
            A_SCR: rd_mux = scratch_q;
`endif
            default: rd_mux = '0;  // control reads 0; unmapped reads 0
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csr_readdata      <= '0;
            csr_readdatavalid <= 1'b0;
        end else begin
            csr_readdatavalid <= csr_read;
            if (csr_read) begin
                csr_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_emif_csr_rst_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for emif_csr_rst_ctrl. Directed steps cover reset,
// register map and the calibration outcomes. Randomized calibration trials are
// then checked against an outcome model built directly from the sequencing
// rules. Build with or without EMIF_CSR_SCRATCH_EN.
// -----------------------------------------------------------------------------
module tb_emif_csr_rst_ctrl;

    localparam int          NUM_CH      = 4;
    localparam logic [7:0]  CH_MASK     = 8'h0F;
    localparam logic [63:0] DFH_VAL     = 64'h3_00000_00B000_1009;
    localparam int          RST_CYCLES  = 16;
    localparam int          CAL_TIMEOUT = 100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [11:0]       csr_addr = '0;
    logic              csr_write = 1'b0;
    logic [63:0]       csr_writedata = '0;
    logic              csr_read = 1'b0;
    logic [63:0]       csr_readdata;
    logic              csr_readdatavalid;
    logic              mem_rst;
    logic [NUM_CH-1:0] cal_success = '0;
    logic [NUM_CH-1:0] cal_fail = '0;
    logic              mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    emif_csr_rst_ctrl #(
        .NUM_CH      (NUM_CH),
        .CH_MASK     (CH_MASK),
        .DFH_VAL     (DFH_VAL),
        .RST_CYCLES  (RST_CYCLES),
        .CAL_TIMEOUT (CAL_TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .csr_addr          (csr_addr),
        .csr_write         (csr_write),
        .csr_writedata     (csr_writedata),
        .csr_read          (csr_read),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .mem_rst           (mem_rst),
        .cal_success       (cal_success),
        .cal_fail          (cal_fail),
        .mem_ready         (mem_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Status word as the register map defines it.
    function automatic logic [63:0] sts(input int st, input bit to,
                                        input logic [3:0] f, input logic [3:0] s);
        return (64'(st) << 17) | (64'(to) << 16) | (64'(f) << 8) | 64'(s);
    endfunction

    // All tasks start and end on a falling edge. A read issued at a falling
    // edge returns the register contents of that same clock cycle.
    task automatic csr_rd(input logic [11:0] a, output logic [63:0] d);
        csr_addr = a;
        csr_read = 1'b1;
        @(negedge clk);
        csr_read = 1'b0;
        check("rd_valid", 64'(csr_readdatavalid), 64'd1);
        d = csr_readdata;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
        logic [63:0] d;
        csr_rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [63:0] wd);
        csr_addr      = a;
        csr_writedata = wd;
        csr_write     = 1'b1;
        @(negedge clk);
        csr_write     = 1'b0;
    endtask

    // Simultaneous read and write to the same address.
    task automatic csr_rw(input logic [11:0] a, input logic [63:0] wd, output logic [63:0] d);
        csr_addr      = a;
        csr_writedata = wd;
        csr_write     = 1'b1;
        csr_read      = 1'b1;
        @(negedge clk);
        csr_write     = 1'b0;
        csr_read      = 1'b0;
        check("rw_valid", 64'(csr_readdatavalid), 64'd1);
        d = csr_readdata;
    endtask

    // Counts cycles with mem_rst high, bounded so a stuck reset cannot hang.
    task automatic count_rst(input int start, output int n);
        n = start;
        while (mem_rst === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // One calibration attempt: trigger a restart, check the reset hold, apply
    // (s, f) from WAIT_CAL cycle d onward and check the resulting status.
    task automatic run_trial(input string name, input int d,
                             input logic [3:0] s, input logic [3:0] f);
        int          n, e;
        logic [63:0] exp_fin;
        cal_success = '0;
        cal_fail    = '0;
        csr_wr(12'h018, 64'h1);
        check({name, "_mem_rst_trig"}, 64'(mem_rst), 64'd1);
        rd_chk({name, "_sts_rst"}, 12'h008, sts(0, 0, 4'h0, 4'h0));
        count_rst(1, n);
        check({name, "_rst_len"}, 64'(n), 64'(RST_CYCLES));
        // Outcome model: inputs are first seen in WAIT_CAL cycle d; the wait
        // lasts at most CAL_TIMEOUT cycles (0..CAL_TIMEOUT-1).
        if (d < CAL_TIMEOUT && (f != 4'h0 || s == 4'hF)) begin
            e = d;
            exp_fin = (f != 4'h0) ? sts(3, 0, f, s) : sts(2, 0, 4'h0, s);
        end else begin
            e = CAL_TIMEOUT - 1;
            exp_fin = (d < CAL_TIMEOUT) ? sts(3, 1, 4'h0, s) : sts(3, 1, 4'h0, 4'h0);
        end
        for (int k = 0; k < e; k++) begin
            if (k == d) begin
                cal_success = s;
                cal_fail    = f;
            end
            @(negedge clk);
        end
        if (d == e) begin
            cal_success = s;
            cal_fail    = f;
        end
        rd_chk({name, "_sts_last_wait"}, 12'h008, sts(1, 0, 4'h0, 4'h0));
        rd_chk({name, "_sts_exit"}, 12'h008, exp_fin);
        check({name, "_mem_ready"}, 64'(mem_ready), 64'(exp_fin[18:17] == 2'd2));
    endtask

    initial begin
        int          n;
        logic [63:0] d;
        int          td;
        logic [3:0]  ts, tf;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_mem_rst",   64'(mem_rst), 64'd1);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_rdvalid",   64'(csr_readdatavalid), 64'd0);
        check("rst_rddata",    csr_readdata, 64'h0);

        // Release; calibration passes from cycle 20.
        rst = 1'b0;
        count_rst(0, n);
        check("init_rst_len", 64'(n), 64'(RST_CYCLES));
        repeat (4) @(negedge clk);
        cal_success = 4'hF;
        @(negedge clk);
        rd_chk("init_sts_done", 12'h008, 64'h4_000F);
        check("init_mem_ready", 64'(mem_ready), 64'd1);

        // Constant registers, one-cycle latency, no stray valid.
        rd_chk("dfh", 12'h000, 64'h3_00000_00B000_1009);
        rd_chk("cap", 12'h010, 64'h40F);
        @(negedge clk);
        check("rdvalid_idle", 64'(csr_readdatavalid), 64'd0);

        // Writes to read-only offsets are ignored; bit0=0 is not a trigger.
        csr_wr(12'h000, '1);
        csr_wr(12'h008, '1);
        csr_wr(12'h010, '1);
        csr_wr(12'h018, 64'hFFFF_FFFF_FFFF_FFFE);
        rd_chk("dfh_after_wr", 12'h000, 64'h3_00000_00B000_1009);
        rd_chk("sts_after_wr", 12'h008, 64'h4_000F);
        rd_chk("cap_after_wr", 12'h010, 64'h40F);
        rd_chk("ctl_reads_0",  12'h018, 64'h0);
        rd_chk("sts_lowbits",  12'h00F, 64'h4_000F);
        rd_chk("unmapped_28",  12'h028, 64'h0);
        rd_chk("unmapped_ff8", 12'hFF8, 64'h0);

`ifdef EMIF_CSR_SCRATCH_EN
        rd_chk("scr_reset", 12'h020, 64'h0);
        csr_wr(12'h020, 64'hDEAD_BEEF_0123_4567);
        rd_chk("scr_wr", 12'h020, 64'hDEAD_BEEF_0123_4567);
`else
        csr_wr(12'h020, 64'hDEAD_BEEF_0123_4567);
        rd_chk("scr_absent", 12'h020, 64'h0);
`endif

        // Directed calibration outcomes.
        run_trial("timeout",   0, 4'h7, 4'h0);   // 64'h7_0007
        run_trial("fail_wins", 5, 4'hF, 4'h4);   // fail and success together
        run_trial("pass",      3, 4'hF, 4'h0);

        // Read and trigger in the same cycle from DONE.
        csr_rw(12'h018, 64'h1, d);
        check("rw_ctl_pre", d, 64'h0);
        check("rw_mem_rst", 64'(mem_rst), 64'd1);
        rd_chk("rw_sts_cleared", 12'h008, sts(0, 0, 4'h0, 4'h0));
`ifdef EMIF_CSR_SCRATCH_EN
        rd_chk("scr_after_trig", 12'h020, 64'hDEAD_BEEF_0123_4567);
        csr_rw(12'h020, 64'h1111_2222_3333_4444, d);
        check("rw_scr_pre", d, 64'hDEAD_BEEF_0123_4567);
        rd_chk("rw_scr_post", 12'h020, 64'h1111_2222_3333_4444);
`endif

        // Land in FAIL, then rst mid-flight clears status.
        run_trial("pre_rst_fail", 2, 4'h3, 4'h8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_mem_rst",   64'(mem_rst), 64'd1);
        check("midrst_mem_ready", 64'(mem_ready), 64'd0);
        rd_chk("midrst_sts", 12'h008, sts(0, 0, 4'h0, 4'h0));
`ifdef EMIF_CSR_SCRATCH_EN
        rd_chk("midrst_scr", 12'h020, 64'h0);
`endif

        // Randomized calibration trials.
        for (int t = 0; t < 10; t++) begin
            td = $urandom_range(0, CAL_TIMEOUT + 10);
            ts = 4'($urandom_range(0, 15));
            tf = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            if ($urandom_range(0, 3) == 0) ts = 4'hF;
            run_trial($sformatf("rnd%0d", t), td, ts, tf);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
